vpu_operand_collector: RTL and testbench

//  Sequences the shared single-tag lookup port of the 8-lane forwarding unit across up to NSRC source operands per vector instr.

---
 rtl/vpu_fwd_pkg.sv | 30 +++
 rtl/vpu_oc_next_src.sv | 32 +++
 rtl/vpu_operand_collector.sv | 191 +++++++++++++++++++
 tb/tb_vpu_operand_collector.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_fwd_pkg.sv
// Shared definitions for the vector operand collector and its helpers.
//   Lane/element/tag geometry of the 8-lane forwarding unit, the collector
//   FSM state type, the source tag type, and a helper that extracts one
//   slot's tag from a packed tag vector.
package vpu_fwd_pkg;

    localparam int LANES = 8;            // vector lanes
    localparam int EW    = 64;           // element width per lane
    localparam int VREG  = 5;            // vector register index width
    localparam int VER   = 4;            // rename/version width
    localparam int TAGW  = VREG + VER;   // source tag width
    localparam int NSRC  = 3;            // source slots: vs1, vs2, vd-old
    localparam int SRCW  = 2;            // width of a slot index
    localparam int SLOTW = LANES * EW;   // bits of one captured slot

    typedef logic [TAGW-1:0] tag_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PRESENT
    } oc_state_t;

    // Tag of slot s out of a packed {slot NSRC-1, ..., slot 0} vector.
    function automatic tag_t slot_tag(input logic [NSRC*TAGW-1:0] tags,
                                      input logic [SRCW-1:0]      s);
        return tags[s*TAGW +: TAGW];
    endfunction

endpackage

// File: rtl/vpu_oc_next_src.sv
// Find-next-set-bit over the NSRC source-used mask.
//   Returns the lowest set bit of mask whose index is >= start. Start is one
//   bit wider than a slot index so "one past the last slot" is expressible.
// Ports:
//   mask   in   NSRC     source-used mask
//   start  in   SRCW+1   lowest index allowed in the search
//   found  out  1        a set bit exists at or above start
//   idx    out  SRCW     index of that bit (0 when not found)
module vpu_oc_next_src
    import vpu_fwd_pkg::*;
(
    input  logic [NSRC-1:0] mask,
    input  logic [SRCW:0]   start,
    output logic            found,
    output logic [SRCW-1:0] idx
);

    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a value unassigned; otherwise a latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Walk downward so the last match written is the lowest index.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                found = 1'b1;
                idx   = SRCW'(i);
            end
        end
    end

endmodule

// File: rtl/vpu_operand_collector.sv
// Vector operand collector.
//   Accepts one vector instruction (source tags, source-used mask, active
//   lane mask), walks each used source slot in ascending order through the
//   single-tag lookup port of the forwarding unit, waits until every active
//   lane reports ready, captures the lane data (inactive lanes and unused
//   slots read 0), then offers the complete bundle to EX via valid/ready.
// Optional feature: define VPU_OC_TIMEOUT_EN to add a per-source watchdog
//   (parameter TIMEOUT_CYC). On expiry timeout_err pulses for one cycle and
//   the slot is force-captured with whatever data is presented that cycle.
//   Without the macro there is no counter and timeout_err is tied 0.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   issue handshake; req_ready is high only in IDLE
//   req_tags          NSRC*TAGW tags, slot s at [s*TAGW +: TAGW]
//   req_src_mask      slot s used when bit s is set
//   req_lane_mask     active lanes
//   fwd_src_tag       registered tag driven to the forwarding unit
//   fwd_data          LANES*EW combinational reply for fwd_src_tag
//   fwd_ready_mask    per-lane ready from the forwarding unit
//   opnd_valid/ready  EX handshake for the operand bundle
//   opnd_data         NSRC*LANES*EW bundle, slot s at [s*LANES*EW +: LANES*EW]
//   busy              state is not IDLE
//   cur_src           slot currently being collected
//   timeout_err       one-cycle watchdog pulse
module vpu_operand_collector
    import vpu_fwd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NSRC*TAGW-1:0]  req_tags,
    input  logic [NSRC-1:0]       req_src_mask,
    input  logic [LANES-1:0]      req_lane_mask,
    output logic [TAGW-1:0]       fwd_src_tag,
    input  logic [LANES*EW-1:0]   fwd_data,
    input  logic [LANES-1:0]      fwd_ready_mask,
    output logic                  opnd_valid,
    input  logic                  opnd_ready,
    output logic [NSRC*SLOTW-1:0] opnd_data,
    output logic                  busy,
    output logic [SRCW-1:0]       cur_src,
    output logic                  timeout_err
);

    oc_state_t             state;
    logic [NSRC*TAGW-1:0]  tags_q;
    logic [NSRC-1:0]       src_mask_q;
    logic [LANES-1:0]      lane_mask_q;

    logic                  accept;
    logic                  hit;
    logic                  force_cap;
    logic                  capture;
    logic [SLOTW-1:0]      cap_data;

    logic                  first_found;
    logic [SRCW-1:0]       first_idx;
    logic                  next_found;
    logic [SRCW-1:0]       next_idx;

    assign accept  = (state == IDLE) && req_valid && req_ready;
    // Lanes outside the active mask never block; an empty mask hits at once.
    assign hit     = (fwd_ready_mask & lane_mask_q) == lane_mask_q;
    assign capture = (state == COLLECT) && (hit || force_cap);
    assign busy    = (state != IDLE);

    // Inactive lanes are zeroed at capture time so the bundle needs no
    // further masking downstream.
    always_comb begin
        cap_data = '0;
        for (int l = 0; l < LANES; l++) begin
            cap_data[l*EW +: EW] = lane_mask_q[l] ? fwd_data[l*EW +: EW] : '0;
        end
    end

    // First used slot of the incoming request.
    vpu_oc_next_src u_first (
        .mask  (req_src_mask),
        .start ('0),
        .found (first_found),
        .idx   (first_idx)
    );

    // Next used slot strictly above the one being collected.
    vpu_oc_next_src u_next (
        .mask  (src_mask_q),
        .start ({1'b0, cur_src} + (SRCW+1)'(1)),
        .found (next_found),
        .idx   (next_idx)
    );

`ifdef VPU_OC_TIMEOUT_EN
    localparam int             WCW       = $clog2(TIMEOUT_CYC);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

    logic [WCW-1:0] wait_cnt;

    // Fires on the TIMEOUT_CYC-th consecutive non-hit cycle of one source.
    assign force_cap = (state == COLLECT) && !hit && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= force_cap;
            if ((state != COLLECT) || hit || force_cap) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end
        end
    end
`else
    assign force_cap   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the bundle storage is reset on purpose: an aborted
            // request must never leave data that a later bundle could expose.
            state       <= IDLE;
            req_ready   <= 1'b0;
            opnd_valid  <= 1'b0;
            opnd_data   <= '0;
            fwd_src_tag <= '0;
            cur_src     <= '0;
            tags_q      <= '0;
            src_mask_q  <= '0;
            lane_mask_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready   <= 1'b0;
                        tags_q      <= req_tags;
                        src_mask_q  <= req_src_mask;
                        lane_mask_q <= req_lane_mask;
                        opnd_data   <= '0;
                        if (first_found) begin
                            state       <= COLLECT;
                            cur_src     <= first_idx;
                            fwd_src_tag <= slot_tag(req_tags, first_idx);
                        end else begin
                            state      <= PRESENT;
                            opnd_valid <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (capture) begin
                        for (int s = 0; s < NSRC; s++) begin
                            if (SRCW'(s) == cur_src) begin
                                opnd_data[s*SLOTW +: SLOTW] <= cap_data;
                            end
                        end
                        if (next_found) begin
                            cur_src     <= next_idx;
                            fwd_src_tag <= slot_tag(tags_q, next_idx);
                        end else begin
                            state      <= PRESENT;
                            opnd_valid <= 1'b1;
                        end
                    end
                end

                PRESENT: begin
                    if (opnd_ready) begin
                        state      <= IDLE;
                        opnd_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_operand_collector.sv
// Self-checking bench for vpu_operand_collector.
//   A behavioural forwarder replies with lane data derived from the tag and
//   a per-transaction salt. Expected bundles and latencies come from the
//   collector's rules: used slots ascending, one cycle per slot plus one per
//   stall cycle, inactive lanes and unused slots zero.
module tb_vpu_operand_collector;
    import vpu_fwd_pkg::*;

    localparam int BUDGET = 40;
    localparam int TW3    = NSRC * TAGW;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [TW3-1:0]        req_tags;
    logic [NSRC-1:0]       req_src_mask;
    logic [LANES-1:0]      req_lane_mask;
    logic [TAGW-1:0]       fwd_src_tag;
    logic [LANES*EW-1:0]   fwd_data;
    logic [LANES-1:0]      fwd_ready_mask;
    logic                  opnd_valid;
    logic                  opnd_ready;
    logic [NSRC*SLOTW-1:0] opnd_data;
    logic                  busy;
    logic [SRCW-1:0]       cur_src;
    logic                  timeout_err;

    logic [31:0] salt = 32'h0;
    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct {
        logic [TW3-1:0]          tags;
        logic [NSRC-1:0]         src_mask;
        logic [LANES-1:0]        lane_mask;
        logic [NSRC-1:0][3:0]    stall;      // stall cycles before each slot hits
        int                      hold;       // cycles opnd_ready stays low
        bit                      hold_valid; // keep req_valid high afterwards
        int                      exp_lat;    // edges from accept to opnd_valid
    } vec_t;

    always #5 clk = ~clk;

    vpu_operand_collector #(.TIMEOUT_CYC(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_tags       (req_tags),
        .req_src_mask   (req_src_mask),
        .req_lane_mask  (req_lane_mask),
        .fwd_src_tag    (fwd_src_tag),
        .fwd_data       (fwd_data),
        .fwd_ready_mask (fwd_ready_mask),
        .opnd_valid     (opnd_valid),
        .opnd_ready     (opnd_ready),
        .opnd_data      (opnd_data),
        .busy           (busy),
        .cur_src        (cur_src),
        .timeout_err    (timeout_err)
    );

    function automatic logic [EW-1:0] lane_word(input logic [31:0] s, input tag_t t, input int ln);
        return {s, 7'h2B, t, 8'(ln), 8'hC3 ^ 8'(ln)};
    endfunction

    always_comb begin
        fwd_data = '0;
        for (int l = 0; l < LANES; l++) fwd_data[l*EW +: EW] = lane_word(salt, fwd_src_tag, l);
    end

    function automatic logic [NSRC*SLOTW-1:0] model_bundle(input logic [31:0] s, input logic [TW3-1:0] tags,
                                                           input logic [NSRC-1:0] sm, input logic [LANES-1:0] lm);
        logic [NSRC*SLOTW-1:0] b = '0;
        for (int sl = 0; sl < NSRC; sl++)
            for (int ln = 0; ln < LANES; ln++)
                if (sm[sl] && lm[ln]) b[(sl*LANES+ln)*EW +: EW] = lane_word(s, tags[sl*TAGW +: TAGW], ln);
        return b;
    endfunction

    // Active lanes minus the highest one: guarantees a miss for a non-empty mask.
    function automatic logic [LANES-1:0] drop_top(input logic [LANES-1:0] m);
        logic [LANES-1:0] r = m;
        bit done = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) if (m[i] && !done) begin r[i] = 1'b0; done = 1'b1; end
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_bundle(input string nm, input logic [NSRC*SLOTW-1:0] exp);
        for (int s = 0; s < NSRC; s++) begin
            n_vec++;
            if (opnd_data[s*SLOTW +: SLOTW] !== exp[s*SLOTW +: SLOTW]) begin
                n_bad++;
                $display("FAIL %s slot%0d: got %h expected %h", nm, s, opnd_data[s*SLOTW +: SLOTW], exp[s*SLOTW +: SLOTW]);
            end
        end
    endtask

    function automatic vec_t mk(input logic [NSRC-1:0] sm, input logic [LANES-1:0] lm,
                                input logic [NSRC-1:0][3:0] st, input int hold, input bit hv, input int lat);
        vec_t v;
        v.tags = TW3'($urandom);
        v.src_mask = sm;
        v.lane_mask = lm;
        v.stall = st;
        v.hold = hold;
        v.hold_valid = hv;
        v.exp_lat = lat;
        return v;
    endfunction

    // Called and returns at a negedge with the collector idle.
    task automatic run_txn(input vec_t v, input string nm);
        logic [NSRC*SLOTW-1:0] exp_b;
        int q_slot[$];
        bit q_stall[$];
        int lat;
        int s;
        bit st;
        bit got_ready = 1'b0;

        opnd_ready    = 1'b0;
        salt          = $urandom;
        req_tags      = v.tags;
        req_src_mask  = v.src_mask;
        req_lane_mask = v.lane_mask;
        req_valid     = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            if (req_ready) begin got_ready = 1'b1; break; end
            @(negedge clk);
        end
        if (!got_ready) begin
            check({nm, " req_ready wait"}, 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end

        for (int sl = 0; sl < NSRC; sl++) begin
            if (v.src_mask[sl]) begin
                for (int j = 0; j < int'(v.stall[sl]); j++) begin q_slot.push_back(sl); q_stall.push_back(1'b1); end
                q_slot.push_back(sl);
                q_stall.push_back(1'b0);
            end
        end
        exp_b = model_bundle(salt, v.tags, v.src_mask, v.lane_mask);

        @(posedge clk);  // accept edge
        for (lat = 0; lat <= BUDGET; lat++) begin
            @(negedge clk);
            if (lat == 0 && !v.hold_valid) req_valid = 1'b0;
            if (opnd_valid) break;
            if (q_slot.size() > 0) begin
                s  = q_slot.pop_front();
                st = q_stall.pop_front();
                check({nm, " fwd_src_tag"}, 64'(fwd_src_tag), 64'(v.tags[s*TAGW +: TAGW]));
                check({nm, " cur_src"}, 64'(cur_src), 64'(s));
                check({nm, " collect req_ready"}, 64'(req_ready), 64'd0);
                fwd_ready_mask = st ? (drop_top(v.lane_mask) | (8'($urandom) & ~v.lane_mask))
                                    : (v.lane_mask | 8'($urandom));
            end
        end
        check({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({nm, " slots walked"}, 64'(q_slot.size()), 64'd0);
        check({nm, " timeout_err"}, 64'(timeout_err), 64'd0);
        check_bundle({nm, " bundle"}, exp_b);

        for (int h = 0; h < v.hold; h++) begin
            fwd_ready_mask = 8'($urandom);
            @(negedge clk);
            check({nm, " hold valid"}, 64'(opnd_valid), 64'd1);
            check({nm, " hold req_ready"}, 64'(req_ready), 64'd0);
            check_bundle({nm, " hold data"}, exp_b);
        end
        opnd_ready = 1'b1;
        @(negedge clk);
        opnd_ready = 1'b0;
        check({nm, " valid after hs"}, 64'(opnd_valid), 64'd0);
        check({nm, " busy after hs"}, 64'(busy), 64'd0);
        check({nm, " req_ready after hs"}, 64'(req_ready), 64'd1);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " req_ready"}, 64'(req_ready), 64'd0);
        check({nm, " opnd_valid"}, 64'(opnd_valid), 64'd0);
        check({nm, " fwd_src_tag"}, 64'(fwd_src_tag), 64'd0);
        check({nm, " cur_src"}, 64'(cur_src), 64'd0);
        check({nm, " busy"}, 64'(busy), 64'd0);
        check({nm, " timeout_err"}, 64'(timeout_err), 64'd0);
        check_bundle({nm, " opnd_data"}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        logic [TW3-1:0] rt;

        rst = 1'b1; req_valid = 1'b0; req_tags = '0; req_src_mask = '0;
        req_lane_mask = '0; fwd_ready_mask = '0; opnd_ready = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset req_ready", 64'(req_ready), 64'd1);
        check("post-reset busy", 64'(busy), 64'd0);

        // Directed table: two full slots, stalled slot 2 with partial lanes,
        // empty source mask with long hold, mixed stalls, empty lane mask,
        // and a back-to-back chain with req_valid held high.
        tbl.push_back(mk(3'b011, 8'hFF, {4'd0, 4'd0, 4'd0}, 0, 1'b0, 2));
        tbl.push_back(mk(3'b100, 8'h0F, {4'd3, 4'd0, 4'd0}, 1, 1'b0, 4));
        tbl.push_back(mk(3'b000, 8'hA5, {4'd0, 4'd0, 4'd0}, 5, 1'b0, 0));
        tbl.push_back(mk(3'b111, 8'h81, {4'd2, 4'd0, 4'd1}, 2, 1'b0, 6));
        tbl.push_back(mk(3'b101, 8'h00, {4'd0, 4'd0, 4'd0}, 0, 1'b0, 2));
        tbl.push_back(mk(3'b110, 8'h3C, {4'd0, 4'd1, 4'd0}, 1, 1'b1, 3));
        tbl.push_back(mk(3'b001, 8'hFF, {4'd0, 4'd0, 4'd0}, 0, 1'b1, 1));
        tbl.push_back(mk(3'b010, 8'h5A, {4'd0, 4'd0, 4'd0}, 0, 1'b0, 1));
        for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 40; n++) begin
            vec_t v;
            int k;
            v = mk(3'($urandom), 8'($urandom), '0, $urandom_range(0, 2), 1'($urandom), 0);
            if (n % 6 == 0) v.lane_mask = 8'hFF;
            k = 0;
            for (int s = 0; s < NSRC; s++) begin
                if (v.src_mask[s]) begin
                    k++;
                    if (v.lane_mask != 8'h00) begin
                        v.stall[s] = 4'($urandom_range(0, 3));
                        k += int'(v.stall[s]);
                    end
                end
            end
            v.exp_lat = k;
            run_txn(v, $sformatf("rand%0d", n));
        end

        // Reset while slot 1 is being collected, then a clean request.
        salt = $urandom;
        rt = TW3'($urandom);
        req_tags = rt; req_src_mask = 3'b011; req_lane_mask = 8'hFF; req_valid = 1'b1;
        check("abort accept ready", 64'(req_ready), 64'd1);
        fwd_ready_mask = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort cur_src", 64'(cur_src), 64'd1);
        check("abort fwd_src_tag", 64'(fwd_src_tag), 64'(rt[TAGW +: TAGW]));
        fwd_ready_mask = 8'h7F;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(mk(3'b100, 8'hF0, {4'd1, 4'd0, 4'd0}, 0, 1'b0, 2), "after abort");

`ifdef VPU_OC_TIMEOUT_EN
        // Forwarder never ready: forced capture on the fourth wait cycle.
        begin
            logic [NSRC*SLOTW-1:0] eb;
            salt = $urandom;
            rt = TW3'($urandom);
            req_tags = rt; req_src_mask = 3'b001; req_lane_mask = 8'hFF; req_valid = 1'b1;
            fwd_ready_mask = 8'h00;
            eb = model_bundle(salt, rt, 3'b001, 8'hFF);
            check("wd accept ready", 64'(req_ready), 64'd1);
            @(posedge clk);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                req_valid = 1'b0;
                check("wd wait timeout_err", 64'(timeout_err), 64'd0);
                check("wd wait opnd_valid", 64'(opnd_valid), 64'd0);
            end
            @(negedge clk);
            check("wd pulse", 64'(timeout_err), 64'd1);
            check("wd presented", 64'(opnd_valid), 64'd1);
            check_bundle("wd forced data", eb);
            opnd_ready = 1'b1;
            @(negedge clk);
            opnd_ready = 1'b0;
            check("wd pulse end", 64'(timeout_err), 64'd0);
            check("wd valid drop", 64'(opnd_valid), 64'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
